// File: rtl/fc_layer_if.sv
// fc_layer_if: weight-load, input-beat and result buses of fc_layer.
//   master (producer/consumer side): drives weight_en, weight, ivalid, din,
//   relu_en; observes wdone, iready, ovalid, dout, dout_idx, olast.
//   slave (fc_layer): the mirror image.
interface fc_layer_if #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 6,
  parameter int NEURONS = 10,
  parameter int ACC_W   = 32,
  parameter int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
);
  logic                    weight_en;
  logic [DATA_W-1:0]       weight;
  logic                    wdone;
  logic                    ivalid;
  logic [LANES*DATA_W-1:0] din;
  logic                    iready;
  logic                    relu_en;
  logic                    ovalid;
  logic [ACC_W-1:0]        dout;
  logic [IDX_W-1:0]        dout_idx;
  logic                    olast;

  modport master (
    output weight_en, weight, ivalid, din, relu_en,
    input  wdone, iready, ovalid, dout, dout_idx, olast
  );
  modport slave (
    input  weight_en, weight, ivalid, din, relu_en,
    output wdone, iready, ovalid, dout, dout_idx, olast
  );
endinterface

// File: rtl/fc_layer.sv
// fc_layer: fully-connected layer, NEURONS outputs over an IN_LEN input
// vector. Weights are loaded serially (neuron-major) into a RAM organised
// as LANES words per row, so row c holds exactly the weights consumed at
// compute step c. The input vector is buffered LANES samples per beat,
// then each neuron's dot product is computed at LANES MACs per cycle.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset
//   bus    fc_layer_if.slave (weights, input beats, results)

// One signed multiplier lane, full 2*DATA_W precision.
module fc_mac_lane #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic signed [2*DATA_W-1:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

module fc_layer #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 6,
  parameter int IN_LEN  = 192,
  parameter int NEURONS = 10,
  parameter int ACC_W   = 32
) (
  input logic     i_clk,
  input logic     i_rst,
  fc_layer_if.slave bus
);
  localparam int BEATS = IN_LEN / LANES;
  localparam int ROWS  = NEURONS * BEATS;
  localparam int RW    = (ROWS    > 1) ? $clog2(ROWS)    : 1;
  localparam int BW    = (BEATS   > 1) ? $clog2(BEATS)   : 1;
  localparam int LW    = (LANES   > 1) ? $clog2(LANES)   : 1;
  localparam int NW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int PW    = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMPUTE} state_t;
  state_t r_state, w_next;

  logic [LANES-1:0][DATA_W-1:0] r_wmem [ROWS];
  logic [LANES-1:0][DATA_W-1:0] r_fbuf [BEATS];

  logic [RW-1:0]    r_wrow, r_c;
  logic [LW-1:0]    r_wlane;
  logic [BW-1:0]    r_bcnt, r_b, r_s1_b;
  logic [NW-1:0]    r_n, r_s1_n, r_idx;
  logic             r_wdone, r_issue, r_relu, r_s1_vld, r_ovalid, r_olast;
  logic [ACC_W-1:0] r_sum, r_acc, r_dout;

  logic w_wacc, w_iready, w_bacc, w_last_beat, w_s1_final;
  logic [LANES-1:0][DATA_W-1:0] w_x, w_w;
  logic [LANES-1:0][PW-1:0]     w_p;
  logic [ACC_W-1:0]             w_sum, w_tot;

  // Weights only land in IDLE; a weight word also blocks input that cycle.
  assign w_wacc      = bus.weight_en & (r_state == S_IDLE);
  assign w_iready    = r_wdone & (r_state != S_COMPUTE) & ~bus.weight_en;
  assign w_bacc      = bus.ivalid & w_iready;
  assign w_last_beat = w_bacc & (r_bcnt == BW'(BEATS-1));
  // Stage 1 holds the last beat of the last neuron: final result next edge.
  assign w_s1_final  = r_s1_vld & (r_s1_b == BW'(BEATS-1)) &
                       (r_s1_n == NW'(NEURONS-1));

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_last_beat) w_next = S_COMPUTE;
                 else if (w_bacc) w_next = S_FILL;
      S_FILL:    if (w_last_beat) w_next = S_COMPUTE;
      S_COMPUTE: if (w_s1_final)  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // ---------------- storage (not reset) ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wacc) r_wmem[r_wrow][r_wlane] <= bus.weight;
    if (!i_rst && w_bacc) r_fbuf[r_bcnt] <= bus.din;
  end

  // ---------------- load / input counters ----------------
  // Address kept as (row, lane) so no divider is needed. wdone clears
  // naturally on the next accepted word because the address has wrapped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrow  <= '0;
      r_wlane <= '0;
      r_wdone <= 1'b0;
      r_bcnt  <= '0;
      r_relu  <= 1'b0;
    end else begin
      if (w_wacc) begin
        if (r_wlane == LW'(LANES-1)) begin
          r_wlane <= '0;
          if (r_wrow == RW'(ROWS-1)) begin
            r_wrow  <= '0;
            r_wdone <= 1'b1;
          end else begin
            r_wrow  <= r_wrow + 1'b1;
            r_wdone <= 1'b0;
          end
        end else begin
          r_wlane <= r_wlane + 1'b1;
          r_wdone <= 1'b0;
        end
      end
      if (w_bacc) r_bcnt <= w_last_beat ? '0 : r_bcnt + 1'b1;
      if (w_last_beat) r_relu <= bus.relu_en;
    end
  end

  // ---------------- issue counter c = n*BEATS + b ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_issue <= 1'b0;
      r_c     <= '0;
      r_b     <= '0;
      r_n     <= '0;
    end else if (w_last_beat) begin
      r_issue <= 1'b1;
      r_c     <= '0;
      r_b     <= '0;
      r_n     <= '0;
    end else if (r_issue) begin
      r_c <= r_c + 1'b1;
      if (r_c == RW'(ROWS-1)) r_issue <= 1'b0;
      if (r_b == BW'(BEATS-1)) begin
        r_b <= '0;
        r_n <= r_n + 1'b1;
      end else begin
        r_b <= r_b + 1'b1;
      end
    end
  end

  // ---------------- lanes ----------------
  assign w_x = r_fbuf[r_b];
  assign w_w = r_wmem[r_c];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_mac_lane #(.DATA_W(DATA_W)) u_mac (
      .i_a (w_x[l]),
      .i_b (w_w[l]),
      .o_p (w_p[l])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++)
      w_sum = w_sum + {{(ACC_W-PW){w_p[l][PW-1]}}, w_p[l]};
  end

  // Running total including the stage-1 sum; the b==0 case restarts it.
  assign w_tot = (r_s1_b == '0) ? r_sum : r_acc + r_sum;

  // ---------------- stage 1 / stage 2 ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_b   <= '0;
      r_s1_n   <= '0;
      r_sum    <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
      r_idx    <= '0;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
    end else begin
      r_s1_vld <= r_issue;
      r_s1_b   <= r_b;
      r_s1_n   <= r_n;
      r_sum    <= w_sum;
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      if (r_s1_vld) begin
        r_acc <= w_tot;
        if (r_s1_b == BW'(BEATS-1)) begin
          r_dout   <= (r_relu && w_tot[ACC_W-1]) ? '0 : w_tot;
          r_idx    <= r_s1_n;
          r_ovalid <= 1'b1;
          r_olast  <= (r_s1_n == NW'(NEURONS-1));
        end
      end
    end
  end

  assign bus.wdone    = r_wdone;
  assign bus.iready   = w_iready;
  assign bus.ovalid   = r_ovalid;
  assign bus.dout     = r_dout;
  assign bus.dout_idx = r_idx;
  assign bus.olast    = r_olast;
endmodule

// File: tb/tb_fc_layer.sv
module tb_fc_layer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wmode = 0;
  int   xmode = 0;
  int   exp_q [10];

  always #5 clk = ~clk;

  fc_layer_if bus ();
  fc_layer dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  // weight for neuron n, element i
  function automatic int wval(input int n, input int i);
    byte b;
    b = byte'((n * 192 + i) % 256);
    case (wmode)
      0:       return 1;
      1:       return n - 5;
      2:       return -128;
      default: return int'(b);
    endcase
  endfunction

  function automatic int xval(input int i);
    case (xmode)
      0:       return 1;
      1:       return -128;
      default: return (i % 7) - 3;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_weights(input bit with_iv);
    for (int k = 0; k < 1920; k++) begin
      bus.weight_en = 1'b1;
      bus.weight    = 8'(wval(k / 192, k % 192));
      bus.ivalid    = with_iv;
      bus.din       = '1;
      if (with_iv && k == 3) begin
        n_cmp++;
        if (bus.iready !== 1'b0) begin
          n_bad++; $display("FAIL iready_with_weight_en got %b want 0", bus.iready);
        end
      end
      @(posedge clk); #1;
      if (k == 0 || k == 1918) begin
        n_cmp++;
        if (bus.wdone !== 1'b0) begin
          n_bad++; $display("FAIL wdone_midload k=%0d got %b want 0", k, bus.wdone);
        end
      end
    end
    bus.weight_en = 1'b0;
    bus.ivalid    = 1'b0;
    n_cmp++;
    if (bus.wdone !== 1'b1) begin
      n_bad++; $display("FAIL wdone_after_load got %b want 1", bus.wdone);
    end
  endtask

  // Sends one vector, then checks n_stop results (value, index, olast, timing).
  task automatic run_vector(input bit gap, input bit hold, input bit relu,
                            input int n_stop, input string tag);
    logic [47:0] d;
    int k, got;
    for (int b = 0; b < 32; b++) begin
      for (int l = 0; l < 6; l++) d[l*8 +: 8] = 8'(xval(b * 6 + l));
      bus.din = d; bus.ivalid = 1'b1; bus.relu_en = relu;
      @(posedge clk); #1;
      if (gap && b < 31) begin
        bus.ivalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    // relu_en must have been captured already; flip it to prove that
    bus.relu_en = ~relu;
    bus.ivalid = hold; bus.weight_en = hold; bus.weight = 8'h55;
    k = 0; got = 0;
    while (got < n_stop && k < 400) begin
      @(posedge clk); #1; k++;
      if (hold && k == 10) begin
        n_cmp++;
        if (bus.iready !== 1'b0) begin
          n_bad++; $display("FAIL %s iready_compute got %b want 0", tag, bus.iready);
        end
      end
      if (bus.ovalid) begin
        n_cmp++;
        if (bus.dout !== 32'(exp_q[got])) begin
          n_bad++; $display("FAIL %s dout[%0d] got %0d want %0d", tag, got, $signed(bus.dout), exp_q[got]);
        end
        n_cmp++;
        if (bus.dout_idx !== 4'(got)) begin
          n_bad++; $display("FAIL %s dout_idx got %0d want %0d", tag, bus.dout_idx, got);
        end
        n_cmp++;
        if (bus.olast !== (got == 9)) begin
          n_bad++; $display("FAIL %s olast[%0d] got %b want %b", tag, got, bus.olast, got == 9);
        end
        n_cmp++;
        if (k != (got + 1) * 32 + 1) begin
          n_bad++; $display("FAIL %s timing[%0d] got %0d want %0d", tag, got, k, (got + 1) * 32 + 1);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != n_stop) begin
      n_bad++; $display("FAIL %s result_count got %0d want %0d", tag, got, n_stop);
    end
    bus.ivalid = 1'b0; bus.weight_en = 1'b0;
    if (n_stop == 10) begin
      #1;
      n_cmp++;
      if (bus.iready !== 1'b1) begin
        n_bad++; $display("FAIL %s iready_after got %b want 1", tag, bus.iready);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.wdone    !== 1'b0) begin n_bad++; $display("FAIL rst_wdone got %b want 0", bus.wdone); end
    n_cmp++; if (bus.iready   !== 1'b0) begin n_bad++; $display("FAIL rst_iready got %b want 0", bus.iready); end
    n_cmp++; if (bus.ovalid   !== 1'b0) begin n_bad++; $display("FAIL rst_ovalid got %b want 0", bus.ovalid); end
    n_cmp++; if (bus.olast    !== 1'b0) begin n_bad++; $display("FAIL rst_olast got %b want 0", bus.olast); end
    n_cmp++; if (bus.dout     !== 32'd0) begin n_bad++; $display("FAIL rst_dout got %0d want 0", bus.dout); end
    n_cmp++; if (bus.dout_idx !== 4'd0) begin n_bad++; $display("FAIL rst_idx got %0d want 0", bus.dout_idx); end
  endtask

  task automatic test_no_weights();
    bus.ivalid = 1'b1; bus.din = '1;
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.iready !== 1'b0) begin
        n_bad++; $display("FAIL iready_no_weights got %b want 0", bus.iready);
      end
    end
    bus.ivalid = 1'b0;
  endtask

  task automatic test_ones();
    wmode = 0; xmode = 0;
    load_weights(1'b0);
    for (int n = 0; n < 10; n++) exp_q[n] = 192;
    run_vector(1'b0, 1'b0, 1'b0, 10, "ones");
  endtask

  task automatic test_signed_relu();
    wmode = 1; xmode = 0;
    load_weights(1'b1);   // ivalid held with weight_en: beats must drop
    for (int n = 0; n < 10; n++) exp_q[n] = -960 + 192 * n;
    run_vector(1'b0, 1'b0, 1'b0, 10, "signed");
    for (int n = 0; n < 10; n++) exp_q[n] = (n < 6) ? 0 : -960 + 192 * n;
    run_vector(1'b0, 1'b0, 1'b1, 10, "relu");
  endtask

  task automatic test_minneg();
    wmode = 2; xmode = 1;
    load_weights(1'b0);
    for (int n = 0; n < 10; n++) exp_q[n] = 3145728;
    run_vector(1'b0, 1'b0, 1'b0, 10, "minneg");
  endtask

  task automatic test_ramp();
    longint s;
    wmode = 3; xmode = 2;
    load_weights(1'b0);
    for (int n = 0; n < 10; n++) begin
      s = 0;
      for (int i = 0; i < 192; i++) s += longint'(wval(n, i)) * longint'(xval(i));
      exp_q[n] = int'(s);
    end
    run_vector(1'b0, 1'b0, 1'b0, 10, "ramp");
  endtask

  task automatic test_gapped_hold();
    run_vector(1'b1, 1'b1, 1'b0, 10, "gapped");
    run_vector(1'b0, 1'b0, 1'b0, 10, "after_hold");
  endtask

  task automatic test_reset_mid();
    int cnt;
    wmode = 0; xmode = 0;
    load_weights(1'b0);
    for (int n = 0; n < 10; n++) exp_q[n] = 192;
    run_vector(1'b0, 1'b0, 1'b0, 4, "pre_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.wdone !== 1'b0) begin n_bad++; $display("FAIL midrst_wdone got %b want 0", bus.wdone); end
    n_cmp++; if (bus.iready !== 1'b0) begin n_bad++; $display("FAIL midrst_iready got %b want 0", bus.iready); end
    cnt = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (bus.ovalid) cnt++;
    end
    n_cmp++;
    if (cnt != 0) begin n_bad++; $display("FAIL midrst_ovalid got %0d pulses want 0", cnt); end
    load_weights(1'b0);
    run_vector(1'b0, 1'b0, 1'b0, 10, "post_rst");
  endtask

  initial begin
    bus.weight_en = 1'b0; bus.weight = '0; bus.ivalid = 1'b0;
    bus.din = '0; bus.relu_en = 1'b0;
    do_reset();
    test_reset();
    test_no_weights();
    test_ones();
    test_signed_relu();
    test_minneg();
    test_ramp();
    test_gapped_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fc_layer.md
# fc_layer

Parametrised fully-connected layer: the multi-neuron successor to the single-output `fc` block in the CNN accelerator. It stores a full `NEURONS x IN_LEN` signed weight matrix, loaded serially, and buffers one input vector that arrives `LANES` samples per beat. It then computes every neuron's signed dot product sequentially, `LANES` MACs per cycle, with optional ReLU. It sits after the last pooling stage and feeds the classifier/argmax stage.

## Interface
- `DATA_W`, 8: width of input samples and weights (signed).
- `LANES`, 6: samples per input beat and MACs per cycle.
- `IN_LEN`, 192: input vector length. Must be a multiple of `LANES`. `BEATS = IN_LEN/LANES`.
- `NEURONS`, 10: number of output neurons.
- `ACC_W`, 32: accumulator and `dout` width (signed).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `weight_en`  in  1  weight word valid.
- `weight`  in  `DATA_W`  signed weight, neuron-major order: word k goes to neuron k/IN_LEN, element k%IN_LEN.
- `wdone`  out  1  high once all `NEURONS*IN_LEN` weights are loaded.
- `ivalid`  in  1  input beat valid.
- `din`  in  `LANES*DATA_W`  packed signed samples. Lane l occupies bits [l*DATA_W +: DATA_W] and is element `beat*LANES+l`.
- `iready`  out  1  block accepts `ivalid` this cycle.
- `relu_en`  in  1  clamp negative results to 0. Sampled when the last input beat is accepted.
- `ovalid`  out  1  one-cycle pulse per neuron result.
- `dout`  out  `ACC_W`  signed result.
- `dout_idx`  out  `clog2(NEURONS)`  neuron index of `dout`.
- `olast`  out  1  high with `ovalid` for neuron `NEURONS-1`.

## Operation
- **States.**
  - IDLE: no beats buffered.
  - FILL: 1..BEATS-1 beats buffered.
  - COMPUTE.
- **Weight load.**
  - Accepted only in IDLE; `weight_en` in FILL or COMPUTE is ignored and the word is dropped.
  - Each accepted word is written at address `wcnt`, and `wcnt` increments.
  - At `wcnt = NEURONS*IN_LEN-1`, `wcnt` wraps to 0 and `wdone` is set.
  - An accepted word while `wdone=1` clears `wdone` and starts a fresh load at address 0. Reloading always restarts.
- **Input.**
  - `iready = wdone & (state != COMPUTE) & !weight_en`.
  - If `weight_en` and `ivalid` are both high in IDLE, the weight wins and the beat is dropped.
  - Each accepted beat is stored in the feature buffer at beat index `bcnt`.
  - Accepting beat `BEATS-1` captures `relu_en`, sets `bcnt=0`, and enters COMPUTE.
- **Compute.**
  - Counter c runs 0..NEURONS*BEATS-1, with n=c/BEATS and b=c%BEATS.
  - Each cycle: the `LANES` products `din[b][l]*w[n][b*LANES+l]`, each full precision at 2*DATA_W, are summed sign-extended and registered (stage 1).
  - Stage 2: `acc <= (b==0) ? sum : acc+sum`.
  - At b=BEATS-1: `dout <= relu ? max(acc+sum,0) : acc+sum`, `dout_idx <= n`, `ovalid <= 1`, and `olast <= (n==NEURONS-1)`.
- **Arithmetic.** Two's complement, wraps at `ACC_W`, no saturation.
- **Completion.** After the last neuron's result is issued, the state returns to IDLE. Weights and `wdone` persist between vectors.
- **Reset.**
  - `rst` returns to IDLE and clears `wcnt`, `bcnt`, c, `acc`, and `relu`.
  - Outputs go to: `ovalid=0`, `olast=0`, `dout=0`, `dout_idx=0`, `wdone=0`, `iready=0`.
  - Weight RAM contents are not cleared, but `wdone=0` forces a reload before any input is accepted.
  - Reset mid-load or mid-compute aborts the operation; no further `ovalid` is produced.

## Timing
- Edge T is the edge that accepts the last input beat.
- The result of neuron n is on `dout`/`ovalid` in the cycle after edge T+(n+1)*BEATS+1. Results arrive back-to-back, one every `BEATS` cycles.
- With defaults: neuron 0 appears after edge T+33 and neuron 9 after edge T+321. `iready` is high again after edge T+321.
- Weight load takes exactly `NEURONS*IN_LEN` accepted cycles. `wdone` is high in the cycle after the final word's edge. Defaults: 1920 cycles.
- `ivalid` may be gapped arbitrarily; only accepted beats count.
- `ovalid` is never high for two consecutive cycles unless BEATS=1.

## Test plan
- Defaults, all weights 1, all samples 1, relu_en=0 → 10 pulses, each `dout=192`, `dout_idx` 0..9, `olast` only on idx 9, spaced 32 cycles apart.
- Neuron n weights = n-5, samples 1 → `dout` = -960, -768, -576, -384, -192, 0, 192, 384, 576, 768. Repeat with relu_en=1 → first six are 0.
- All weights -128, all samples -128 → every `dout=3145728`. Ramp weights (k%256 as signed) are checked against the golden model.
- Input beats alternating valid/idle (32 valid in 64 cycles), plus `ivalid` and `weight_en` held high throughout COMPUTE → results identical to the gapless case, no extra beats accepted, weights unchanged.
- `ivalid` before `wdone`, and `ivalid` together with `weight_en` in IDLE → beats dropped, `iready=0`, `bcnt` stays 0.
- `rst` pulsed after neuron 3's output → no further `ovalid`, `wdone=0`; reload weights and a new vector → correct 10 results.
